circular_fifo: RTL and testbench

Parametrised circular-buffer FIFO for the QuickRS232 byte path, sitting between the UART receiver/transmitter and user logic. It replaces shift-register storage with read/write pointers, so every push and pop completes in a single cycle. It accepts simultaneous push and pop, and reports fill level, almost-full/almost-empty thresholds and sticky overflow/underflow errors. Push and pop are per-cycle strobes, not held-level requests.

---
 rtl/circular_fifo.sv | 138 +++++++++++++
 tb/tb_circular_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/circular_fifo.sv
// Circular-buffer byte FIFO with read/write pointers, fill level, threshold flags
// and sticky overflow/underflow errors. Single-cycle push and pop, latency-1 read data.
module circular_fifo #(
   parameter int FIFO_SIZE          = 16,
   parameter int DATA_WIDTH         = 8,
   parameter int ALMOST_FULL_LEVEL  = FIFO_SIZE - 2,
   parameter int ALMOST_EMPTY_LEVEL = 2,
   localparam int LW                = $clog2(FIFO_SIZE + 1)
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic                  flush,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic                  fifo_ready,
   output logic                  empty,
   output logic                  full,
   output logic [LW-1:0]         level,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int PW = $clog2(FIFO_SIZE);

   typedef enum logic {
      ST_RESET,
      ST_IDLE
   } state_t;

   state_t state, state_next;

   logic [DATA_WIDTH-1:0] mem [FIFO_SIZE];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [LW-1:0]         level_next;
   logic                  push_ok, pop_ok, flush_ok, ovf_set, unf_set;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(FIFO_SIZE - 1))
         return '0;
      else
         return p + PW'(1);
   endfunction

   always_ff @(posedge clk or posedge clear) begin
      if (clear)
         state <= ST_RESET;
      else
         state <= state_next;
   end

   // Requests are only honoured once the block has left the reset state.
   always_comb begin
      state_next = state;
      push_ok    = 1'b0;
      pop_ok     = 1'b0;
      flush_ok   = 1'b0;
      ovf_set    = 1'b0;
      unf_set    = 1'b0;
      case (state)
         ST_RESET: state_next = ST_IDLE;
         ST_IDLE: begin
            if (flush) begin
               flush_ok = 1'b1;
            end else begin
               push_ok = push & (~full | pop);
               pop_ok  = pop & ~empty;
               ovf_set = push & full & ~pop;
               unf_set = pop & empty;
            end
         end
         default: state_next = ST_RESET;
      endcase
   end

   assign fifo_ready = (state == ST_IDLE);

   always_comb begin
      level_next = level;
      if (flush_ok)
         level_next = '0;
      else if (push_ok && !pop_ok)
         level_next = level + LW'(1);
      else if (pop_ok && !push_ok)
         level_next = level - LW'(1);
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         out_data     <= '0;
         out_valid    <= 1'b0;
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         level        <= level_next;
         empty        <= (level_next == '0);
         full         <= (level_next == LW'(FIFO_SIZE));
         almost_full  <= (level_next >= LW'(ALMOST_FULL_LEVEL));
         almost_empty <= (level_next <= LW'(ALMOST_EMPTY_LEVEL));
         out_valid    <= pop_ok;
         if (flush_ok) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end else begin
            if (push_ok)
               wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok) begin
               rd_ptr   <= ptr_inc(rd_ptr);
               out_data <= mem[rd_ptr];
            end
            if (ovf_set)
               overflow <= 1'b1;
            if (unf_set)
               underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_circular_fifo.sv
// Bench for circular_fifo: queue-based reference model on a 5-deep instance checked every
// cycle, directed literal checks, and a threshold walk on an 8-deep instance.
module tb_circular_fifo;

   localparam int FS = 5;
   localparam int AF = 3;
   localparam int AE = 2;

   logic       clk = 1'b0;
   logic       clear = 1'b1;
   logic       flush = 1'b0, push = 1'b0, pop = 1'b0;
   logic [7:0] in_data = '0;
   logic [7:0] out_data;
   logic       out_valid, fifo_ready, empty, full, almost_full, almost_empty, overflow, underflow;
   logic [2:0] level;

   logic       flush_b = 1'b0, push_b = 1'b0, pop_b = 1'b0;
   logic [7:0] in_b = '0;
   logic [7:0] out_data_b;
   logic       out_valid_b, fifo_ready_b, empty_b, full_b, almost_full_b, almost_empty_b;
   logic       overflow_b, underflow_b;
   logic [3:0] level_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   circular_fifo #(.FIFO_SIZE(FS), .DATA_WIDTH(8), .ALMOST_FULL_LEVEL(AF),
                   .ALMOST_EMPTY_LEVEL(AE)) dut_a (
      .clk(clk), .clear(clear), .flush(flush), .push(push), .pop(pop), .in_data(in_data),
      .out_data(out_data), .out_valid(out_valid), .fifo_ready(fifo_ready), .empty(empty),
      .full(full), .level(level), .almost_full(almost_full), .almost_empty(almost_empty),
      .overflow(overflow), .underflow(underflow));

   circular_fifo #(.FIFO_SIZE(8), .DATA_WIDTH(8), .ALMOST_FULL_LEVEL(6),
                   .ALMOST_EMPTY_LEVEL(2)) dut_b (
      .clk(clk), .clear(clear), .flush(flush_b), .push(push_b), .pop(pop_b), .in_data(in_b),
      .out_data(out_data_b), .out_valid(out_valid_b), .fifo_ready(fifo_ready_b),
      .empty(empty_b), .full(full_b), .level(level_b), .almost_full(almost_full_b),
      .almost_empty(almost_empty_b), .overflow(overflow_b), .underflow(underflow_b));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: a queue of stored entries plus sticky error bits.
   logic [7:0] mq[$];
   bit         m_ready = 1'b0, m_out_valid = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
   logic [7:0] m_out_data = '0;
   bit         m_full, m_empty;

   always @(posedge clk or posedge clear) begin
      if (clear) begin
         mq.delete();
         m_ready = 1'b0; m_out_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_out_data = '0;
      end else if (!m_ready) begin
         m_ready = 1'b1;
         m_out_valid = 1'b0;
      end else if (flush) begin
         mq.delete();
         m_ovf = 1'b0; m_unf = 1'b0; m_out_valid = 1'b0;
      end else begin
         m_full  = (mq.size() == FS);
         m_empty = (mq.size() == 0);
         if (push && m_full && !pop) m_ovf = 1'b1;
         if (pop && m_empty) m_unf = 1'b1;
         m_out_valid = pop && !m_empty;
         if (pop && !m_empty) m_out_data = mq.pop_front();
         if (push && (!m_full || pop)) mq.push_back(in_data);
      end
   end

   always @(negedge clk) begin
      chk("level", 32'(level), 32'(mq.size()));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == FS));
      chk("almost_full", 32'(almost_full), 32'(mq.size() >= AF));
      chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= AE));
      chk("fifo_ready", 32'(fifo_ready), 32'(m_ready));
      chk("out_valid", 32'(out_valid), 32'(m_out_valid));
      chk("out_data", 32'(out_data), 32'(m_out_data));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
   end

   task automatic step(input bit p, input bit q, input bit f, input logic [7:0] d);
      push = p; pop = q; flush = f; in_data = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   logic [7:0] exp5 [5];
   logic [8:0] ae_tab;
   logic [8:0] af_tab;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(fifo_ready), 32'h0);
      chk("rst_empty", 32'(empty), 32'h1);
      chk("rst_level", 32'(level), 32'h0);

      clear = 1'b0;
      step(1, 0, 0, 8'h99);
      chk("release_push_ignored", 32'(level), 32'h0);
      chk("release_ready", 32'(fifo_ready), 32'h1);

      for (int i = 0; i < 5; i++) step(1, 0, 0, 8'h11 + 8'(i));
      chk("fill_full", 32'(full), 32'h1);
      chk("fill_level", 32'(level), 32'h5);
      chk("fill_af", 32'(almost_full), 32'h1);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 8'h00);
         chk("pop3_data", 32'(out_data), 32'h11 + 32'(i));
         chk("pop3_valid", 32'(out_valid), 32'h1);
      end
      for (int i = 0; i < 3; i++) step(1, 0, 0, 8'hA1 + 8'(i));
      chk("wrap_level", 32'(level), 32'h5);
      exp5 = '{8'h14, 8'h15, 8'hA1, 8'hA2, 8'hA3};
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 0, 8'h00);
         chk("drain_data", 32'(out_data), 32'(exp5[i]));
      end
      chk("drain_empty", 32'(empty), 32'h1);
      step(0, 0, 0, 8'h00);
      chk("valid_drops", 32'(out_valid), 32'h0);
      chk("data_holds", 32'(out_data), 32'hA3);

      for (int i = 0; i < 5; i++) step(1, 0, 0, 8'h21 + 8'(i));
      step(1, 1, 0, 8'h77);
      chk("fullpp_data", 32'(out_data), 32'h21);
      chk("fullpp_level", 32'(level), 32'h5);
      chk("fullpp_ovf", 32'(overflow), 32'h0);
      step(1, 0, 0, 8'h88);
      chk("ovf_set", 32'(overflow), 32'h1);
      chk("ovf_level", 32'(level), 32'h5);
      exp5 = '{8'h22, 8'h23, 8'h24, 8'h25, 8'h77};
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 0, 8'h00);
         chk("ovf_drain_data", 32'(out_data), 32'(exp5[i]));
      end
      step(0, 1, 0, 8'h00);
      chk("unf_set", 32'(underflow), 32'h1);
      chk("unf_valid", 32'(out_valid), 32'h0);
      chk("ovf_sticky", 32'(overflow), 32'h1);

      for (int i = 0; i < 4; i++) step(1, 0, 0, 8'h31 + 8'(i));
      step(0, 1, 0, 8'h00);
      chk("preflush_level", 32'(level), 32'h3);
      step(1, 1, 1, 8'hEE);
      chk("flush_level", 32'(level), 32'h0);
      chk("flush_empty", 32'(empty), 32'h1);
      chk("flush_ovf", 32'(overflow), 32'h0);
      chk("flush_unf", 32'(underflow), 32'h0);
      chk("flush_valid", 32'(out_valid), 32'h0);
      chk("flush_data_holds", 32'(out_data), 32'h31);
      step(1, 0, 0, 8'h5A);
      step(0, 1, 0, 8'h00);
      chk("post_flush_data", 32'(out_data), 32'h5A);

      step(1, 1, 0, 8'h42);
      chk("emptypp_level", 32'(level), 32'h1);
      chk("emptypp_unf", 32'(underflow), 32'h1);
      chk("emptypp_valid", 32'(out_valid), 32'h0);
      step(0, 1, 0, 8'h00);
      chk("emptypp_data", 32'(out_data), 32'h42);
      step(0, 0, 1, 8'h00);

      step(1, 0, 0, 8'h61);
      step(1, 0, 0, 8'h62);
      step(0, 1, 0, 8'h00);
      push = 1'b0; pop = 1'b0;
      #1 clear = 1'b1;
      #1;
      chk("async_level", 32'(level), 32'h0);
      chk("async_data", 32'(out_data), 32'h0);
      chk("async_valid", 32'(out_valid), 32'h0);
      chk("async_ready", 32'(fifo_ready), 32'h0);
      chk("async_empty", 32'(empty), 32'h1);
      @(posedge clk);
      #1;
      clear = 1'b0;
      step(1, 0, 0, 8'h66);
      chk("release2_level", 32'(level), 32'h0);
      chk("release2_ready", 32'(fifo_ready), 32'h1);
      step(1, 0, 0, 8'h67);
      step(0, 1, 0, 8'h00);
      chk("after_reset_data", 32'(out_data), 32'h67);
      step(0, 0, 0, 8'h00);

      // Threshold walk: almost_empty at levels 0..2, almost_full at levels 6..8.
      ae_tab = 9'b0_0000_0111;
      af_tab = 9'b1_1100_0000;
      for (int lvl = 1; lvl <= 8; lvl++) begin
         push_b = 1'b1; in_b = 8'(lvl);
         @(posedge clk);
         #1;
         chk("thr_up_level", 32'(level_b), 32'(lvl));
         chk("thr_up_ae", 32'(almost_empty_b), 32'(ae_tab[lvl]));
         chk("thr_up_af", 32'(almost_full_b), 32'(af_tab[lvl]));
      end
      push_b = 1'b0;
      chk("thr_full", 32'(full_b), 32'h1);
      for (int lvl = 7; lvl >= 0; lvl--) begin
         pop_b = 1'b1;
         @(posedge clk);
         #1;
         chk("thr_dn_level", 32'(level_b), 32'(lvl));
         chk("thr_dn_ae", 32'(almost_empty_b), 32'(ae_tab[lvl]));
         chk("thr_dn_af", 32'(almost_full_b), 32'(af_tab[lvl]));
         chk("thr_dn_data", 32'(out_data_b), 32'(8 - lvl));
      end
      pop_b = 1'b0;
      @(posedge clk);
      #1;
      chk("thr_empty", 32'(empty_b), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
